// File: rtl/key_scan_debounce.sv
// 4x4 keypad matrix scanner: samples one column per clock, debounces whole-frame
// key images and queues one registered key-press event per clock, lowest key first.
module key_scan_debounce #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] VAL,
  input  logic       CR,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic       KEY_VALID,
  output logic [3:0] KEY_CODE,
  output logic       KEY_HELD
);

  localparam int SCW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [SCW-1:0] CntMax = SCW'(DEBOUNCE_FRAMES);

  logic [15:0]    raw_q, raw_d;
  logic [15:0]    lastFrame_q, lastFrame_d;
  logic [15:0]    debounced_q, debounced_d;
  logic [15:0]    pending_q, pending_d;
  logic [SCW-1:0] stableCnt_q, stableCnt_d;
  logic           keyValid_q, keyValid_d;
  logic [3:0]     keyCode_q, keyCode_d;
  logic           keyHeld_q, keyHeld_d;

  logic [15:0] frame;
  logic [15:0] newPress;
  logic [15:0] grant;
  logic [3:0]  grantIdx;

  assign COL = 4'b0001 << VAL;

  always_comb begin
    raw_d       = raw_q;
    lastFrame_d = lastFrame_q;
    stableCnt_d = stableCnt_q;
    debounced_d = debounced_q;
    newPress    = '0;
    grantIdx    = '0;

    raw_d[{VAL, 2'b00} +: 4] = ROW;
    // The last column of a frame arrives live on ROW, so it is spliced in here.
    frame = {ROW, raw_q[11:0]};

    if (CR) begin
      lastFrame_d = frame;
      if (frame == lastFrame_q) begin
        stableCnt_d = (stableCnt_q == CntMax) ? CntMax : stableCnt_q + SCW'(1);
      end else begin
        stableCnt_d = SCW'(1);
      end
      if (stableCnt_d == CntMax) begin
        newPress    = frame & ~debounced_q;
        debounced_d = frame;
      end
    end

    // Isolate the lowest pending key; a fresh press of the same bit re-sets it.
    grant     = pending_q & (~pending_q + 16'd1);
    pending_d = (pending_q & ~grant) | newPress;
    for (int i = 15; i >= 0; i--) begin
      if (pending_q[i]) grantIdx = 4'(i);
    end

    keyValid_d = (pending_q != '0);
    keyCode_d  = (pending_q != '0) ? grantIdx : keyCode_q;
    keyHeld_d  = |debounced_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      raw_q       <= '0;
      lastFrame_q <= '0;
      debounced_q <= '0;
      pending_q   <= '0;
      stableCnt_q <= '0;
      keyValid_q  <= 1'b0;
      keyCode_q   <= '0;
      keyHeld_q   <= 1'b0;
    end else begin
      raw_q       <= raw_d;
      lastFrame_q <= lastFrame_d;
      debounced_q <= debounced_d;
      pending_q   <= pending_d;
      stableCnt_q <= stableCnt_d;
      keyValid_q  <= keyValid_d;
      keyCode_q   <= keyCode_d;
      keyHeld_q   <= keyHeld_d;
    end
  end

  assign KEY_VALID = keyValid_q;
  assign KEY_CODE  = keyCode_q;
  assign KEY_HELD  = keyHeld_q;

endmodule

// File: doc/key_scan_debounce.md
# key_scan_debounce

Keypad matrix scanner and debouncer for the 4x4 LaunchPad button grid. It sits directly downstream of the 2-bit scan counter and consumes that counter's column index (`VAL`) and end-of-frame carry (`CR`). Each cycle it drives one keypad column and samples the four row lines. Over repeated 4-cycle frames it builds a 16-bit key image, debounces it across consecutive frames, and emits one registered key-press event per clock for every newly stable pressed key.

## Interface
- `DEBOUNCE_FRAMES`, default 3: number of consecutive identical frames required before the key image is accepted. Legal range is ≥ 2.
- `CLK` input, 1 bit: system clock, rising-edge active.
- `RST` input, 1 bit: reset, asynchronous and active-high. Clears all state.
- `VAL` input, 2 bits: current scan column index from the scan counter, which counts 0,1,2,3 and then wraps.
- `CR` input, 1 bit: scan counter carry. High exactly when `VAL` == 3, marking the last column of a frame.
- `ROW` input, 4 bits: keypad row sense lines, active-high, valid in the same cycle as the `COL` that selects them.
- `COL` output, 4 bits: one-hot column drive, equal to `1 << VAL`. Combinational.
- `KEY_VALID` output, 1 bit: registered 1-cycle pulse, one per new key press.
- `KEY_CODE` output, 4 bits: index of the reported key, k = 4*VAL + r. Registered and valid when `KEY_VALID` = 1.
- `KEY_HELD` output, 1 bit: registered. High while any debounced key is pressed.

## Operation
- **Key index:** k = 4*col + row. For example, `VAL`=1 with `ROW[2]` gives k = 6.
- **Sampling:** on every `CLK` edge, `raw[4*VAL+3 : 4*VAL] <= ROW`.
- **Frame completion:** on an edge where `CR` = 1, the completed frame is F = {`ROW`, `raw[11:0]`}.
- **Frame-end updates** (edge with `CR` = 1 only):
  - If F == `last_frame`: `stable_cnt` increments, saturating at `DEBOUNCE_FRAMES`.
  - Otherwise: `stable_cnt` <= 1.
  - In both cases: `last_frame` <= F.
  - If the updated `stable_cnt` == `DEBOUNCE_FRAMES`:
    - `new_press` = F & ~`debounced`.
    - `debounced` <= F.
  - Otherwise `new_press` = 0.
- **Event queue:** 16-bit `pending` mask, updated every edge as `pending` <= (`pending` & ~`grant`) | `new_press`.
  - `grant` is the one-hot lowest set bit of `pending`, or 0 when `pending` is empty.
- **Emission:** every edge, `KEY_VALID` <= (`pending` != 0) and `KEY_CODE` <= index of `grant`.
  - When `pending` is empty, `KEY_CODE` holds its last value.
- **Releases:** produce no event. A released key only clears its `debounced` bit.
- **Hold flag:** `KEY_HELD` <= |`debounced`, registered and updated the edge after `debounced` changes.
- **Repeat presses:** a key already in `debounced` never re-enters `pending` until it has first been debounced as released.
- **Simultaneous grant and new press of the same bit:** the bit stays pending, because the `new_press` OR term wins.
- **Registers:**
  - 16-bit `raw`.
  - 16-bit `last_frame`.
  - 16-bit `debounced`.
  - 16-bit `pending`.
  - `stable_cnt` of width clog2(`DEBOUNCE_FRAMES`+1).
  - The output registers.

## Timing
- **Reset values** while `RST` = 1, asynchronously:
  - `raw`, `last_frame`, `debounced`, `pending`, `stable_cnt` = 0.
  - `KEY_VALID` = 0, `KEY_CODE` = 0, `KEY_HELD` = 0.
  - `COL` follows `VAL`. Upstream reset gives `VAL` = 0, so `COL` = 4'b0001.
- **Frame length:** 4 cycles. A frame boundary is the edge with `CR` = 1.
- **Latency:** a press first sampled in frame n is accepted at the end of frame n+`DEBOUNCE_FRAMES`-1, at edge E0.
  - E0: `pending` is set.
  - E1 (next edge): `KEY_VALID` = 1.
  - Minimum press-to-event time is therefore 4*`DEBOUNCE_FRAMES`+1 edges from the first sampled column of that frame.
- **Throughput:** one event per cycle. m simultaneous new presses give m back-to-back `KEY_VALID` cycles in ascending k order.
  - 16 presses drain within 16 cycles, spanning 4 frames. New presses arriving during a drain merge into `pending` without loss.
- **Contact bounce:** any frame differing from the previous one restarts `stable_cnt` at 1. `debounced` is unchanged until `DEBOUNCE_FRAMES` identical frames have been seen.
- **Reset mid-frame or mid-drain:** all queued events are discarded, and the debounce restarts from an all-zero image.
  - Keys still held after reset are reported again once stable.
- **`CR` consistency:** if `CR` = 1 while `VAL` != 3 (an upstream fault), the frame-end logic still executes on that edge. No special handling.

## Test plan
- **Reset:** assert `RST` mid-operation with `pending` != 0.
  - Outputs go to 0 immediately, without waiting for a clock.
  - After release, `COL` = 0001.
  - No `KEY_VALID` appears until a new stable press.
- **Single press:** `DEBOUNCE_FRAMES`=3, `ROW`=0100 whenever `VAL`=1, held constant.
  - Exactly one `KEY_VALID` pulse with `KEY_CODE`=6, one edge after the 3rd frame's `CR` edge.
  - `KEY_HELD`=1 from the same edge onward.
- **Bounce rejection:** key 6 present in alternate frames for 10 frames.
  - `KEY_VALID` and `KEY_HELD` stay 0 throughout.
- **Multi-key press:** keys 3 (`VAL`=0, `ROW[3]`), 12 (`VAL`=3, `ROW[0]`) and 9 pressed in the same frames.
  - Three consecutive `KEY_VALID` cycles with codes 3, 9, 12.
- **Release:** release key 6 after it has been held.
  - `KEY_HELD` falls one edge after the 3rd stable empty frame.
  - No `KEY_VALID` on release.
  - Re-pressing key 6 produces a new event with code 6.
- **Sweep:** `COL` checked one-hot against `VAL` for all 4 values.
  - Pressing all 16 keys at once gives 16 back-to-back events, codes 0 through 15.
